// File: rtl/debug_master_pkg.sv
// Shared types and widths for the debug bus master and its timeout timer.
package debug_master_pkg;
  localparam int DBG_ADDR_WIDTH = 15;
  localparam int DBG_DATA_WIDTH = 32;
  localparam int TIMER_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RV,
    ST_RSP
  } state_e;
endpackage

// File: rtl/debug_master_timer.sv
// Wait-cycle counter with synchronous clear; expired marks the last allowed cycle of a wait.
module debug_master_timer
  import debug_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of cycles already spent waiting, so the
  // TIMEOUT_CYCLES-th waiting cycle is the one where count == TIMEOUT_CYCLES-1.
  assign expired = enable && (count >= TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/debug_bus_master.sv
// Host-command to core-debug-port bridge: one outstanding request/grant/rvalid transaction with timeout.
module debug_bus_master
  import debug_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [DBG_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DBG_DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DBG_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      debug_req_o,
  output logic                      debug_we_o,
  output logic [DBG_ADDR_WIDTH-1:0] debug_addr_o,
  output logic [DBG_DATA_WIDTH-1:0] debug_wdata_o,
  input  logic                      debug_gnt_i,
  input  logic                      debug_rvalid_i,
  input  logic [DBG_DATA_WIDTH-1:0] debug_rdata_i,
  output logic                      busy_o
);

  state_e                    state, state_next;
  logic                      cmd_load;
  logic                      rsp_load;
  logic [DBG_DATA_WIDTH-1:0] rsp_rdata_next;
  logic                      rsp_err_next;
  logic                      timer_clear;
  logic                      timer_enable;
  logic                      timer_expired;

  debug_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk_i),
    .rst_n  (rstn_i),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Awaited events are checked before the timeout so a coincident event wins.
  always_comb begin
    state_next     = state;
    cmd_load       = 1'b0;
    rsp_load       = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_load   = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (debug_gnt_i) begin
          state_next = ST_WAIT_RV;
        end else if (timer_expired) begin
          rsp_load     = 1'b1;
          rsp_err_next = 1'b1;
          state_next   = ST_RSP;
        end
      end
      ST_WAIT_RV: begin
        if (debug_rvalid_i) begin
          rsp_load       = 1'b1;
          rsp_rdata_next = debug_we_o ? '0 : debug_rdata_i;
          state_next     = ST_RSP;
        end else if (timer_expired) begin
          rsp_load     = 1'b1;
          rsp_err_next = 1'b1;
          state_next   = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign timer_enable = (state == ST_REQ) || (state == ST_WAIT_RV);
  assign timer_clear  = (state_next != state);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      debug_we_o    <= 1'b0;
      debug_addr_o  <= '0;
      debug_wdata_o <= '0;
    end else if (cmd_load) begin
      debug_we_o    <= cmd_we_i;
      debug_addr_o  <= cmd_addr_i;
      debug_wdata_o <= cmd_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (rsp_load) begin
      rsp_rdata_o <= rsp_rdata_next;
      rsp_err_o   <= rsp_err_next;
    end
  end

  assign cmd_ready_o = (state == ST_IDLE);
  assign debug_req_o = (state == ST_REQ);
  assign rsp_valid_o = (state == ST_RSP);
  assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed bench: instance 0 uses the default timeout, instance 1 a timeout of 4, instance 2 a timeout of 3.
module tb_debug_bus_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  debug_req, debug_we, debug_gnt, debug_rvalid, busy;
  logic [14:0] cmd_addr [3];
  logic [14:0] debug_addr [3];
  logic [31:0] cmd_wdata [3];
  logic [31:0] rsp_rdata [3];
  logic [31:0] debug_wdata [3];
  logic [31:0] debug_rdata [3];

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int TO = (g == 0) ? 255 : ((g == 1) ? 4 : 3);
    debug_bus_master #(.TIMEOUT_CYCLES(TO)) u_dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .cmd_valid_i   (cmd_valid[g]),
      .cmd_ready_o   (cmd_ready[g]),
      .cmd_we_i      (cmd_we[g]),
      .cmd_addr_i    (cmd_addr[g]),
      .cmd_wdata_i   (cmd_wdata[g]),
      .rsp_valid_o   (rsp_valid[g]),
      .rsp_ready_i   (rsp_ready[g]),
      .rsp_rdata_o   (rsp_rdata[g]),
      .rsp_err_o     (rsp_err[g]),
      .debug_req_o   (debug_req[g]),
      .debug_we_o    (debug_we[g]),
      .debug_addr_o  (debug_addr[g]),
      .debug_wdata_o (debug_wdata[g]),
      .debug_gnt_i   (debug_gnt[g]),
      .debug_rvalid_i(debug_rvalid[g]),
      .debug_rdata_i (debug_rdata[g]),
      .busy_o        (busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one accepting edge; the expected response is queued at issue time.
  task automatic issue(input int i, input logic we, input logic [14:0] addr, input logic [31:0] wdata,
                       input bit push, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    cmd_valid[i] = 1'b1;
    cmd_we[i]    = we;
    cmd_addr[i]  = addr;
    cmd_wdata[i] = wdata;
    check("cmd_ready_idle", 32'(cmd_ready[i]), 32'd1);
    if (push) begin
      e.inst  = i;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
    end
    tick();
    cmd_valid[i] = 1'b0;
  endtask

  // Response monitor: every handshake pops one expected response.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rstn && rsp_valid[i] && rsp_ready[i]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: inst %0d got rdata %h err %0b, required no response",
                   i, rsp_rdata[i], rsp_err[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_inst", 32'(i), 32'(e.inst));
          check("rsp_rdata", rsp_rdata[i], e.rdata);
          check("rsp_err", 32'(rsp_err[i]), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn         = 1'b0;
    cmd_valid    = '0;
    cmd_we       = '0;
    rsp_ready    = 3'b111;
    debug_gnt    = '0;
    debug_rvalid = '0;
    for (int i = 0; i < 3; i++) begin
      cmd_addr[i]    = '0;
      cmd_wdata[i]   = '0;
      debug_rdata[i] = '0;
    end
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'h7);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req", 32'(debug_req), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata[0], 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Minimum-latency read: accept at N, req at N+1, rsp_valid at N+3.
    issue(0, 1'b0, 15'h0400, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    check("rd_req_n1", 32'(debug_req[0]), 32'd1);
    check("rd_addr", 32'(debug_addr[0]), 32'h0400);
    debug_gnt[0] = 1'b1;
    tick();
    debug_gnt[0]    = 1'b0;
    check("rd_req_dropped", 32'(debug_req[0]), 32'd0);
    check("rd_rsp_n2", 32'(rsp_valid[0]), 32'd0);
    debug_rvalid[0] = 1'b1;
    debug_rdata[0]  = 32'hDEADBEEF;
    tick();
    debug_rvalid[0] = 1'b0;
    debug_rdata[0]  = 32'h0;
    check("rd_rsp_n3", 32'(rsp_valid[0]), 32'd1);
    tick();
    check("rd_idle_after", 32'(busy[0]), 32'd0);

    // rvalid coincident with gnt must be ignored.
    issue(0, 1'b0, 15'h0010, 32'h0, 1'b1, 32'h22222222, 1'b0);
    debug_gnt[0]    = 1'b1;
    debug_rvalid[0] = 1'b1;
    debug_rdata[0]  = 32'h11111111;
    tick();
    debug_gnt[0]    = 1'b0;
    debug_rvalid[0] = 1'b0;
    tick();
    check("gnt_rv_waiting", 32'(rsp_valid[0]), 32'd0);
    debug_rvalid[0] = 1'b1;
    debug_rdata[0]  = 32'h22222222;
    tick();
    debug_rvalid[0] = 1'b0;
    tick();

    // Write with gnt in the sixth REQ cycle; write response carries rdata 0.
    issue(0, 1'b1, 15'h2000, 32'h00000001, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("wr_req_held", 32'(debug_req[0]), 32'd1);
      check("wr_addr_held", 32'(debug_addr[0]), 32'h2000);
      check("wr_wdata_held", debug_wdata[0], 32'h00000001);
      check("wr_we_held", 32'(debug_we[0]), 32'd1);
      if (k == 5) debug_gnt[0] = 1'b1;
      tick();
    end
    debug_gnt[0]    = 1'b0;
    debug_rvalid[0] = 1'b1;
    debug_rdata[0]  = 32'hFFFFFFFF;
    tick();
    debug_rvalid[0] = 1'b0;
    tick();

    // Response back-pressure for 10 cycles with a competing command pending.
    issue(0, 1'b0, 15'h0020, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
    rsp_ready[0] = 1'b0;
    debug_gnt[0] = 1'b1;
    tick();
    debug_gnt[0]    = 1'b0;
    debug_rvalid[0] = 1'b1;
    debug_rdata[0]  = 32'h0BADF00D;
    tick();
    debug_rvalid[0] = 1'b0;
    debug_rdata[0]  = 32'h0;
    cmd_valid[0]    = 1'b1;
    cmd_we[0]       = 1'b1;
    cmd_addr[0]     = 15'h0030;
    cmd_wdata[0]    = 32'h00000055;
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata_stable", rsp_rdata[0], 32'h0BADF00D);
      check("bp_cmd_ready", 32'(cmd_ready[0]), 32'd0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    check("bp_not_accepted_in_rsp", 32'(cmd_ready[0]), 32'd1);
    check("bp_idle_after_hs", 32'(busy[0]), 32'd0);
    begin
      exp_t e;
      e.inst = 0; e.rdata = 32'h0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    tick();
    cmd_valid[0] = 1'b0;
    check("bp_second_addr", 32'(debug_addr[0]), 32'h0030);
    debug_gnt[0] = 1'b1;
    tick();
    debug_gnt[0]    = 1'b0;
    debug_rvalid[0] = 1'b1;
    tick();
    debug_rvalid[0] = 1'b0;
    tick();

    // Grant timeout with TIMEOUT_CYCLES=4; late rvalid afterwards is discarded.
    issue(1, 1'b0, 15'h0044, 32'h0, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("to_req_held", 32'(debug_req[1]), 32'd1);
      tick();
    end
    check("to_req_dropped", 32'(debug_req[1]), 32'd0);
    check("to_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    tick();
    debug_rvalid[1] = 1'b1;
    debug_rdata[1]  = 32'h77777777;
    tick();
    debug_rvalid[1] = 1'b0;
    check("late_rv_busy", 32'(busy[1]), 32'd0);
    check("late_rv_no_rsp", 32'(rsp_valid[1]), 32'd0);

    // Grant on the same cycle as the timeout with TIMEOUT_CYCLES=3.
    issue(2, 1'b0, 15'h0003, 32'h0, 1'b1, 32'hCAFE0003, 1'b0);
    tick();
    tick();
    debug_gnt[2] = 1'b1;
    tick();
    debug_gnt[2] = 1'b0;
    check("coinc_busy", 32'(busy[2]), 32'd1);
    check("coinc_no_rsp", 32'(rsp_valid[2]), 32'd0);
    debug_rvalid[2] = 1'b1;
    debug_rdata[2]  = 32'hCAFE0003;
    tick();
    debug_rvalid[2] = 1'b0;
    tick();

    // Reset in WAIT_RV aborts without a response; the next read completes.
    issue(0, 1'b0, 15'h0100, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    debug_gnt[0] = 1'b1;
    tick();
    debug_gnt[0] = 1'b0;
    check("rst_mid_busy_before", 32'(busy[0]), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    check("rst_mid_addr", 32'(debug_addr[0]), 32'h0);
    check("rst_mid_wdata", debug_wdata[0], 32'h0);
    check("rst_mid_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_mid_rdata", rsp_rdata[0], 32'h0);
    tick();
    rstn = 1'b1;
    tick();
    issue(0, 1'b0, 15'h0400, 32'h0, 1'b1, 32'h12345678, 1'b0);
    debug_gnt[0] = 1'b1;
    tick();
    debug_gnt[0]    = 1'b0;
    debug_rvalid[0] = 1'b1;
    debug_rdata[0]  = 32'h12345678;
    tick();
    debug_rvalid[0] = 1'b0;
    check("post_rst_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    tick();
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
